// File: rtl/token_dispenser_pkg.sv
// rtl/token_dispenser_pkg.sv - shared constants, state encoding and verb codes for the token dispenser
package token_dispenser_pkg;

    localparam int DEF_PERIOD_CYC  = 1000000;
    localparam int DEF_REST_CYC    = 50000;
    localparam int DEF_PUSH_CYC    = 100000;
    localparam int DEF_HOLD_FRAMES = 15;
    localparam int DEF_RET_FRAMES  = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_PUSH = 3'd2,
        ST_RET  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Command verbs decoded upstream; dispense sits next to ping.
    localparam logic [7:0] v_ping = 8'd2;
    localparam logic [7:0] v_disp = 8'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/token_dispenser_servo_pwm.sv
// rtl/token_dispenser_servo_pwm.sv - free-running servo frame with frame-aligned pulse width
module token_dispenser_servo_pwm
    import token_dispenser_pkg::*;
#(
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int REST_CYC   = DEF_REST_CYC,
    parameter int PW         = $clog2(PERIOD_CYC)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] width,
    output logic          frame_tick,
    output logic          pwm
);

    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] width_q, width_d;
    logic          pwm_q, pwm_d;

    assign frame_tick = (phase_q == '0);

    // Width is only taken at phase 0, so a mid-frame change never cuts or stretches a pulse.
    always_comb begin
        phase_d = (phase_q == PW'(PERIOD_CYC - 1)) ? '0 : phase_q + 1'b1;
        width_d = frame_tick ? width : width_q;
        pwm_d   = (phase_q < width_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            width_q <= PW'(REST_CYC);
            pwm_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/token_dispenser.sv
// rtl/token_dispenser.sv - sequences servo push/return strokes for a requested token count
module token_dispenser
    import token_dispenser_pkg::*;
#(
    parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int REST_CYC    = DEF_REST_CYC,
    parameter int PUSH_CYC    = DEF_PUSH_CYC,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int RET_FRAMES  = DEF_RET_FRAMES
) (
    input  logic       clk50m,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] count,
    output logic       busy,
    output logic       done,
    output logic [7:0] dispensed,
    output logic       servo_pwm
);

    localparam int PW = $clog2(PERIOD_CYC);
    localparam int FW = $clog2(max_int(HOLD_FRAMES, RET_FRAMES) + 1);
    localparam logic [FW-1:0] HOLD_LAST = FW'(HOLD_FRAMES - 1);
    localparam logic [FW-1:0] RET_LAST  = FW'(RET_FRAMES - 1);

    state_e        state_q, state_d;
    logic [7:0]    remaining_q, remaining_d;
    logic [7:0]    dispensed_q, dispensed_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          frame_tick;
    logic [PW-1:0] width_sel;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dispensed_d = dispensed_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dispensed_d = 8'd0;
                    if (count != 8'd0) begin
                        remaining_d = count;
                        state_d     = ST_ARM;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ARM: begin
                if (frame_tick) begin
                    frame_cnt_d = '0;
                    state_d     = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (frame_tick) begin
                    if (frame_cnt_q == HOLD_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = ST_RET;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            ST_RET: begin
                if (frame_tick) begin
                    if (frame_cnt_q == RET_LAST) begin
                        frame_cnt_d = '0;
                        dispensed_d = dispensed_q + 8'd1;
                        remaining_d = remaining_q - 8'd1;
                        state_d     = (remaining_q == 8'd1) ? ST_DONE : ST_PUSH;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        // Driven from the next state so the frame that starts on the ARM tick is already a push frame.
        width_sel = (state_d == ST_PUSH) ? PW'(PUSH_CYC) : PW'(REST_CYC);
    end

    always_ff @(posedge clk50m or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= 8'd0;
            dispensed_q <= 8'd0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dispensed_q <= dispensed_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dispensed = dispensed_q;

    token_dispenser_servo_pwm #(
        .PERIOD_CYC (PERIOD_CYC),
        .REST_CYC   (REST_CYC),
        .PW         (PW)
    ) u_servo_pwm (
        .clk        (clk50m),
        .rst_n      (reset),
        .width      (width_sel),
        .frame_tick (frame_tick),
        .pwm        (servo_pwm)
    );

endmodule

// File: tb/tb_token_dispenser.sv
// tb/tb_token_dispenser.sv - bench for token_dispenser against a frame-level timing model
module tb_token_dispenser;

    localparam int P   = 100;
    localparam int RW  = 5;
    localparam int PWC = 10;
    localparam int H   = 2;
    localparam int R   = 2;
    localparam int SF  = H + R;

    logic       clk50m = 1'b0;
    logic       reset  = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] count  = 8'd0;
    logic       busy, done, servo_pwm;
    logic [7:0] dispensed;

    token_dispenser #(
        .PERIOD_CYC  (P),
        .REST_CYC    (RW),
        .PUSH_CYC    (PWC),
        .HOLD_FRAMES (H),
        .RET_FRAMES  (R)
    ) dut (
        .clk50m    (clk50m),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .dispensed (dispensed),
        .servo_pwm (servo_pwm)
    );

    always #5 clk50m = ~clk50m;

    int tests = 0;
    int fails = 0;

    // Model: cycle index since reset release plus the most recent accepted job.
    int cyc = 0;
    bit job_v = 1'b0;
    int job_s = 0, job_n = 0, job_t0 = 0, job_end = 0;

    function automatic bit m_busy(input int c);
        return job_v && (c >= job_s + 1) && (c <= job_end);
    endfunction

    function automatic int m_width(input int f);
        if (job_v && job_n > 0 && f >= job_t0 && f < job_t0 + P * SF * job_n &&
            ((f - job_t0) / P) % SF < H)
            return PWC;
        return RW;
    endfunction

    function automatic int m_disp(input int c);
        int k;
        if (!job_v || job_n == 0 || c - 1 < job_t0) return 0;
        k = (c - 1 - job_t0) / (P * SF);
        return (k > job_n) ? job_n : k;
    endfunction

    function automatic int m_pwm(input int c);
        int p;
        p = (c - 1) % P;
        return (p < m_width(c - 1 - p)) ? 1 : 0;
    endfunction

    always @(posedge clk50m) begin
        if (!reset) begin
            cyc   <= 0;
            job_v <= 1'b0;
        end else begin
            if (start && !m_busy(cyc)) begin
                job_v   <= 1'b1;
                job_s   <= cyc;
                job_n   <= int'(count);
                job_t0  <= ((cyc + P) / P) * P;
                job_end <= (count == 8'd0) ? cyc + 1 : ((cyc + P) / P) * P + P * SF * int'(count) + 1;
            end
            cyc <= cyc + 1;
        end
    end

    // Pulse-width and done bookkeeping observed from the DUT pins.
    int run = 0, n10 = 0, n5 = 0, nbad = 0, done_seen = 0;
    always @(negedge clk50m) begin
        if (!reset) begin
            run <= 0;
        end else begin
            if (done) done_seen <= done_seen + 1;
            if (servo_pwm) begin
                run <= run + 1;
            end else if (run > 0) begin
                if (run == PWC) n10 <= n10 + 1;
                if (run == RW) n5 <= n5 + 1;
                if ((run >= 6 && run <= 9) || run >= 11) nbad <= nbad + 1;
                run <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk50m);
            if (reset && cyc >= 1) begin
                chk("busy", int'(busy), int'(m_busy(cyc)));
                chk("done", int'(done), int'(m_busy(cyc) && cyc == job_end));
                chk("dispensed", int'(dispensed), m_disp(cyc));
                chk("servo_pwm", int'(servo_pwm), m_pwm(cyc));
            end
        end
    endtask

    task automatic nxt();
        @(negedge clk50m);
        #1;
    endtask

    task automatic pulse_start(input int n, output int s);
        start = 1'b1;
        count = 8'(n);
        s = cyc;
        nxt();
        start = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        int guard;
        guard = 0;
        while (cyc % P != ph && guard < 2 * P) begin
            nxt();
            guard++;
        end
    endtask

    task automatic wait_sig(input string name, input bit which_done, output int t);
        int guard;
        guard = 0;
        while (((which_done ? done : servo_pwm) !== 1'b1) && guard < 3000) begin
            nxt();
            guard++;
        end
        if (guard >= 3000) chk({name, "_timeout"}, 1, 0);
        t = cyc;
    endtask

    task automatic release_reset();
        nxt();
        reset = 1'b1;
    endtask

    int s, t_rise, t_done, hi, b10, bdone, gap;

    initial begin
        fork
            monitor();
        join_none

        repeat (2) nxt();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dispensed", int'(dispensed), 0);
        chk("rst_pwm", int'(servo_pwm), 0);
        release_reset();

        // Idle: 5 high cycles per frame.
        repeat (P + 3) nxt();
        hi = 0;
        repeat (P) begin
            nxt();
            hi += int'(servo_pwm);
        end
        chk("idle_high_per_frame", hi, 5);
        chk("idle_dispensed", int'(dispensed), 0);

        // count=3 job.
        b10 = n10;
        bdone = done_seen;
        wait_phase(30);
        pulse_start(3, s);
        chk("busy_rise", int'(busy), 1);
        wait_sig("push_rise", 1'b0, t_rise);
        wait_sig("job3_done", 1'b1, t_done);
        chk("job3_push_to_done", t_done - t_rise, 1200);
        repeat (5) nxt();
        chk("job3_dispensed", int'(dispensed), 3);
        chk("job3_push_pulses", n10 - b10, 6);
        chk("job3_done_count", done_seen - bdone, 1);

        // count=0, then a start on the done cycle (ignored) and one a cycle later.
        b10 = n10;
        wait_phase(20);
        pulse_start(0, s);
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 1);
        pulse_start(1, s);
        chk("zero_busy_after", int'(busy), 0);
        pulse_start(0, s);
        chk("b2b_done", int'(done), 1);
        nxt();
        chk("b2b_idle", int'(busy), 0);
        repeat (2 * P) nxt();
        chk("zero_no_push", n10 - b10, 0);

        // Start while busy is ignored.
        pulse_start(2, s);
        repeat (150) nxt();
        pulse_start(5, s);
        wait_sig("busyjob_done", 1'b1, t_done);
        nxt();
        chk("busyjob_dispensed", int'(dispensed), 2);

        // Start at phase 50: push pulse begins at the next phase 0.
        wait_phase(50);
        pulse_start(1, s);
        wait_sig("lat_rise", 1'b0, t_rise);
        chk("start_to_push_rise", t_rise - s, 51);
        wait_sig("lat_done", 1'b1, t_done);

        // Reset in the middle of a push pulse of a count=4 job.
        bdone = done_seen;
        wait_phase(50);
        pulse_start(4, s);
        wait_sig("rst_push_rise", 1'b0, t_rise);
        repeat (P + 2) nxt();
        chk("pre_reset_pwm_high", int'(servo_pwm), 1);
        reset = 1'b0;
        #1;
        chk("reset_pwm_async_low", int'(servo_pwm), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_dispensed", int'(dispensed), 0);
        repeat (3) nxt();
        release_reset();
        b10 = n10;
        repeat (3 * P) nxt();
        chk("reset_no_done", done_seen - bdone, 0);
        chk("reset_no_push", n10 - b10, 0);
        chk("reset_dispensed_after", int'(dispensed), 0);

        // Randomized starts, some landing on busy jobs.
        for (int i = 0; i < 14; i++) begin
            gap = int'($urandom_range(0, 700));
            repeat (gap) nxt();
            pulse_start(int'($urandom_range(0, 3)), s);
        end
        repeat (1400) nxt();

        chk("no_runt_or_stretched", nbad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
